// File: rtl/tag_alloc_enc.sv
// tag_alloc_enc: free-list tag allocator; offers the lowest free tag and decodes released tags back into the mask.
module tag_alloc_enc #(
    parameter int NUM_TAGS = 16,
    parameter int TAG_W    = $clog2(NUM_TAGS),
    parameter int CNT_W    = $clog2(NUM_TAGS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_req,
    output logic             alloc_valid,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             free_valid,
    input  logic [TAG_W-1:0] free_tag,
    output logic [CNT_W-1:0] free_count,
    output logic             full_free,
    output logic             err_double_free,
    output logic             err_alloc_empty
);
    localparam logic [NUM_TAGS-1:0] ONE = NUM_TAGS'(1);
    logic [NUM_TAGS-1:0] free_mask_q, free_mask_d, alloc_oh, free_oh;
    logic [CNT_W-1:0]    free_count_q, free_count_d;
    logic                err_df_q, err_df_d, err_ae_q, err_ae_d;
    logic                alloc_fire, free_in_range, same_tag, double_free, free_fire;
    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        alloc_tag = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--)
            if (free_mask_q[i]) alloc_tag = TAG_W'(i);
    end
    always_comb begin
        alloc_fire    = alloc_req & alloc_valid;
        alloc_oh      = alloc_fire ? (ONE << alloc_tag) : '0;
        free_in_range = 32'(free_tag) < NUM_TAGS;
        free_oh       = free_in_range ? (ONE << free_tag) : '0;
        same_tag      = alloc_fire & (alloc_tag == free_tag);
        // A tag handed out this same cycle may be returned immediately.
        double_free   = free_valid & (~free_in_range | ((|(free_mask_q & free_oh)) & ~same_tag));
        free_fire     = free_valid & ~double_free;
        free_mask_d   = (free_mask_q & ~alloc_oh) | (free_fire ? free_oh : '0);
        free_count_d  = free_count_q - CNT_W'(alloc_fire) + CNT_W'(free_fire);
        err_df_d      = err_df_q | double_free;
        err_ae_d      = err_ae_q | (alloc_req & ~alloc_valid);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_mask_q  <= '1;
            free_count_q <= CNT_W'(NUM_TAGS);
            err_df_q     <= 1'b0;
            err_ae_q     <= 1'b0;
        end else begin
            free_mask_q  <= free_mask_d;
            free_count_q <= free_count_d;
            err_df_q     <= err_df_d;
            err_ae_q     <= err_ae_d;
        end
    end
    assign alloc_valid     = |free_mask_q;
    assign free_count      = free_count_q;
    assign full_free       = free_count_q == CNT_W'(NUM_TAGS);
    assign err_double_free = err_df_q;
    assign err_alloc_empty = err_ae_q;
endmodule

// File: tb/tb_tag_alloc_enc.sv
// tb_tag_alloc_enc: directed vector table, hand sequences for reset/empty corners, and a random stream against a free-set model.
module tb_tag_alloc_enc;
    localparam int N = 16;
    typedef struct {
        logic       a;
        logic       fv;
        logic [3:0] ft;
        logic       ev;
        logic [3:0] et;
        logic [4:0] ec;
        logic       edf;
        logic       eae;
    } vec_t;
    logic       clk, rst, alloc_req, alloc_valid, free_valid, full_free, err_double_free, err_alloc_empty;
    logic [3:0] alloc_tag, free_tag;
    logic [4:0] free_count;
    int         tests, fails;
    vec_t       tbl[25];
    bit         held[N];
    bit         m_df;

    tag_alloc_enc #(.NUM_TAGS(N)) dut (
        .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_valid(alloc_valid), .alloc_tag(alloc_tag),
        .free_valid(free_valid), .free_tag(free_tag), .free_count(free_count), .full_free(full_free),
        .err_double_free(err_double_free), .err_alloc_empty(err_alloc_empty)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic a, input logic fv, input int ft, input logic ev, input int et,
                                input int ec, input logic edf, input logic eae);
        vec_t v;
        v.a = a; v.fv = fv; v.ft = 4'(ft); v.ev = ev; v.et = 4'(et); v.ec = 5'(ec); v.edf = edf; v.eae = eae;
        return v;
    endfunction

    task automatic chk_all(input string tag, input logic ev, input int et, input int ec, input logic edf, input logic eae);
        chk({tag, " valid"}, int'(alloc_valid), int'(ev));
        chk({tag, " tag"}, int'(alloc_tag), et);
        chk({tag, " count"}, int'(free_count), ec);
        chk({tag, " full"}, int'(full_free), int'(ec == N));
        chk({tag, " err_df"}, int'(err_double_free), int'(edf));
        chk({tag, " err_ae"}, int'(err_alloc_empty), int'(eae));
    endtask

    initial begin
        tests = 0; fails = 0;
        rst = 1; alloc_req = 0; free_valid = 0; free_tag = 0;
        for (int i = 0; i < 16; i++) tbl[i] = mk(1, 0, 0, i < 15, i < 15 ? i + 1 : 0, 15 - i, 0, 0);
        tbl[16] = mk(0, 1, 9,  1, 9, 1, 0, 0);
        tbl[17] = mk(0, 1, 3,  1, 3, 2, 0, 0);
        tbl[18] = mk(0, 1, 12, 1, 3, 3, 0, 0);
        tbl[19] = mk(0, 1, 2,  1, 2, 4, 0, 0);
        tbl[20] = mk(1, 1, 2,  1, 2, 4, 0, 0);
        tbl[21] = mk(1, 1, 0,  1, 0, 4, 0, 0);
        tbl[22] = mk(0, 1, 5,  1, 0, 5, 0, 0);
        tbl[23] = mk(0, 1, 5,  1, 0, 5, 1, 0);
        tbl[24] = mk(0, 0, 0,  1, 0, 5, 1, 0);
        #1;
        chk_all("reset", 1, 0, N, 0, 0);
        @(negedge clk) rst = 0;
        @(posedge clk); #1;
        foreach (tbl[k]) begin
            alloc_req = tbl[k].a; free_valid = tbl[k].fv; free_tag = tbl[k].ft;
            @(posedge clk); #1;
            alloc_req = 0; free_valid = 0;
            chk_all($sformatf("vec%0d", k), tbl[k].ev, int'(tbl[k].et), int'(tbl[k].ec), tbl[k].edf, tbl[k].eae);
        end
        // drain the five remaining tags, then request from an empty pool
        for (int i = 0; i < 5; i++) begin
            alloc_req = 1;
            @(posedge clk); #1;
        end
        alloc_req = 0;
        chk_all("drained", 0, 0, 0, 1, 0);
        alloc_req = 1;
        @(posedge clk); #1;
        alloc_req = 0;
        chk_all("alloc_empty", 0, 0, 0, 1, 1);
        @(posedge clk); #1;
        chk_all("sticky", 0, 0, 0, 1, 1);
        #1 rst = 1;
        #1;
        chk_all("async_rst", 1, 0, N, 0, 0);
        @(negedge clk) rst = 0;
        @(posedge clk); #1;
        chk_all("post_rst", 1, 0, N, 0, 0);

        foreach (held[i]) held[i] = 0;
        m_df = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            int  low, cnt, ft;
            bit  a, fv, fire_a, legit;
            low = -1; cnt = 0;
            for (int i = N - 1; i >= 0; i--) if (!held[i]) begin low = i; cnt++; end
            chk("rnd valid", int'(alloc_valid), int'(cnt > 0));
            chk("rnd tag", int'(alloc_tag), low < 0 ? 0 : low);
            chk("rnd count", int'(free_count), cnt);
            chk("rnd err_df", int'(err_double_free), int'(m_df));
            a = $urandom_range(0, 99) < 55;
            fv = 0; ft = 0;
            if ($urandom_range(0, 19) == 0) begin
                fv = 1; ft = $urandom_range(0, N - 1);
            end else if ($urandom_range(0, 99) < 50) begin
                int s = $urandom_range(0, N - 1);
                for (int i = 0; i < N; i++) if (!fv && held[(s + i) % N]) begin fv = 1; ft = (s + i) % N; end
            end
            fire_a = a && cnt > 0;
            if (fire_a && held[low]) begin
                tests++; fails++;
                $display("FAIL rnd reissue: tag %0d issued while still held", low);
            end
            legit = fv && (held[ft] || (fire_a && ft == low));
            if (fv && !legit) m_df = 1;
            if (fire_a) held[low] = 1;
            if (legit) held[ft] = 0;
            alloc_req = a; free_valid = fv; free_tag = 4'(ft);
            @(posedge clk); #1;
        end
        alloc_req = 0; free_valid = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
